// File: rtl/adc_pkg.sv
// Shared constants for the sine-tone ADC stand-in.
// SINE_LUT[k] = round(128 + 127*sin(2*pi*k/256)), stored as offset-binary codes.
package adc_pkg;

  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned PHASE_W   = 16;

  localparam logic [SAMPLE_W-1:0] SINE_LUT [0:LUT_DEPTH-1] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
    8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
    8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
    8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd254, 8'd253,
    8'd253, 8'd252, 8'd251, 8'd250, 8'd250, 8'd249, 8'd248, 8'd246,
    8'd245, 8'd244, 8'd243, 8'd241, 8'd240, 8'd239, 8'd237, 8'd235,
    8'd234, 8'd232, 8'd230, 8'd228, 8'd226, 8'd224, 8'd222, 8'd220,
    8'd218, 8'd216, 8'd213, 8'd211, 8'd209, 8'd206, 8'd204, 8'd201,
    8'd199, 8'd196, 8'd193, 8'd191, 8'd188, 8'd185, 8'd182, 8'd179,
    8'd177, 8'd174, 8'd171, 8'd168, 8'd165, 8'd162, 8'd159, 8'd156,
    8'd153, 8'd150, 8'd147, 8'd144, 8'd140, 8'd137, 8'd134, 8'd131,
    8'd128, 8'd125, 8'd122, 8'd119, 8'd116, 8'd112, 8'd109, 8'd106,
    8'd103, 8'd100, 8'd97,  8'd94,  8'd91,  8'd88,  8'd85,  8'd82,
    8'd79,  8'd77,  8'd74,  8'd71,  8'd68,  8'd65,  8'd63,  8'd60,
    8'd57,  8'd55,  8'd52,  8'd50,  8'd47,  8'd45,  8'd43,  8'd40,
    8'd38,  8'd36,  8'd34,  8'd32,  8'd30,  8'd28,  8'd26,  8'd24,
    8'd22,  8'd21,  8'd19,  8'd17,  8'd16,  8'd15,  8'd13,  8'd12,
    8'd11,  8'd10,  8'd8,   8'd7,   8'd6,   8'd6,   8'd5,   8'd4,
    8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd1,   8'd1,   8'd1,
    8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,
    8'd3,   8'd4,   8'd5,   8'd6,   8'd6,   8'd7,   8'd8,   8'd10,
    8'd11,  8'd12,  8'd13,  8'd15,  8'd16,  8'd17,  8'd19,  8'd21,
    8'd22,  8'd24,  8'd26,  8'd28,  8'd30,  8'd32,  8'd34,  8'd36,
    8'd38,  8'd40,  8'd43,  8'd45,  8'd47,  8'd50,  8'd52,  8'd55,
    8'd57,  8'd60,  8'd63,  8'd65,  8'd68,  8'd71,  8'd74,  8'd77,
    8'd79,  8'd82,  8'd85,  8'd88,  8'd91,  8'd94,  8'd97,  8'd100,
    8'd103, 8'd106, 8'd109, 8'd112, 8'd116, 8'd119, 8'd122, 8'd125
  };

  // Table address is the top byte of the phase accumulator.
  function automatic logic [7:0] lut_index(input logic [PHASE_W-1:0] phase);
    return phase[PHASE_W-1 -: 8];
  endfunction

endpackage

// File: rtl/adc_divider.sv
// Conversion-rate divider: free-running 0..MW-1 counter, tick on the last count.
module adc_divider #(
  parameter int unsigned MW = 5000
) (
  input  logic clk,
  input  logic nrst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(MW - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/adc.sv
// Sine-tone ADC stand-in: phase accumulator + LUT, one conversion per MW cycles,
// delivered through a single-entry valid/ready output register.
module adc
  import adc_pkg::*;
#(
  parameter int unsigned          MW        = 5000,
  parameter logic [PHASE_W-1:0]   PHASE_INC = 16'd1024
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                ready,
  output logic                valid,
  output logic [SAMPLE_W-1:0] sample
);

  logic                tick;
  logic                xfer;
  logic [PHASE_W-1:0]  phase;
  logic [SAMPLE_W-1:0] conv;

  adc_divider #(.MW(MW)) u_divider (
    .clk  (clk),
    .nrst (nrst),
    .tick (tick)
  );

  assign xfer = valid & ready;
  assign conv = SINE_LUT[lut_index(phase)];

  // Phase advances on every tick, even when the conversion is discarded.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + PHASE_INC;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid  <= 1'b0;
      sample <= '0;
    end else if (tick && (!valid || xfer)) begin
      valid  <= 1'b1;
      sample <= conv;
    end else if (xfer) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc.sv
// Self-checking bench for adc: three instances (MW=20, MW=5000, MW=2 with a
// fine phase step) compared every cycle against an arithmetic tone model.
module tb_adc;

  localparam real PI = 3.141592653589793;

  logic       clk = 1'b0;
  logic       nrst_a, nrst_b;
  logic       ready_a, ready_b, ready_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] sample_a, sample_b, sample_c;

  int errors = 0;
  int checks = 0;

  int mw  [3] = '{20, 5000, 2};
  int inc [3] = '{1024, 1024, 256};
  int m_n [3];
  int m_valid [3];
  int m_sample [3];

  logic [2:0] ready_q = '0;
  logic [2:0] nrst_q  = '0;

  int deliv_a [$];
  int deliv_b [$];

  always #5 clk = ~clk;

  adc #(.MW(20)) dut_a (
    .clk(clk), .nrst(nrst_a), .ready(ready_a), .valid(valid_a), .sample(sample_a)
  );
  adc #(.MW(5000)) dut_b (
    .clk(clk), .nrst(nrst_b), .ready(ready_b), .valid(valid_b), .sample(sample_b)
  );
  adc #(.MW(2), .PHASE_INC(16'd256)) dut_c (
    .clk(clk), .nrst(nrst_b), .ready(ready_c), .valid(valid_c), .sample(sample_c)
  );

  function automatic int ref_val(input int idx);
    return $rtoi(128.0 + 127.0 * $sin(2.0 * PI * idx / 256.0) + 0.5);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ready_q <= {ready_c, ready_b, ready_a};
    nrst_q  <= {nrst_b, nrst_b, nrst_a};
  end

  // Reference: tick t (1-based) occurs on edge t*MW and converts phase (t-1)*inc.
  always @(negedge clk) begin
    logic [2:0] rst_now;
    int act_v [3];
    int act_s [3];
    int tk, xf, nv;
    rst_now = {nrst_b, nrst_b, nrst_a};
    act_v = '{int'(valid_a), int'(valid_b), int'(valid_c)};
    act_s = '{int'(sample_a), int'(sample_b), int'(sample_c)};
    for (int i = 0; i < 3; i++) begin
      if (!rst_now[i]) begin
        m_n[i] = 0; m_valid[i] = 0; m_sample[i] = 0;
      end else if (nrst_q[i]) begin
        m_n[i]++;
        tk = ((m_n[i] % mw[i]) == 0);
        xf = m_valid[i] && ready_q[i];
        if (tk) begin
          nv = ref_val((((m_n[i] / mw[i] - 1) * inc[i]) % 65536) / 256);
          if (!m_valid[i] || xf) begin
            m_sample[i] = nv;
            m_valid[i]  = 1;
          end
        end else if (xf) begin
          m_valid[i] = 0;
        end
      end
      chk($sformatf("valid[%0d]", i), act_v[i], m_valid[i]);
      chk($sformatf("sample[%0d]", i), act_s[i], m_sample[i]);
    end
    if (nrst_a && valid_a && ready_a) deliv_a.push_back(int'(sample_a));
    if (nrst_b && valid_b && ready_b) deliv_b.push_back(int'(sample_b));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    nrst_a = 1'b0; nrst_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;

    chk("model_lut0", ref_val(0), 128);
    chk("model_lut4", ref_val(4), 140);
    chk("model_lut16", ref_val(16), 177);
    chk("model_lut64", ref_val(64), 255);
    chk("model_lut128", ref_val(128), 128);
    chk("model_lut192", ref_val(192), 1);

    step(5);
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_sample_a", int'(sample_a), 0);
    chk("rst_valid_b", int'(valid_b), 0);
    chk("rst_sample_b", int'(sample_b), 0);
    nrst_a = 1'b1; nrst_b = 1'b1; ready_c = 1'b1;

    fork
      begin : seq_a
        step(19);
        chk("pre_first_valid", int'(valid_a), 0);
        step(1);
        chk("first_valid", int'(valid_a), 1);
        chk("first_sample", int'(sample_a), 128);
        step(45);
        chk("overrun_valid", int'(valid_a), 1);
        chk("overrun_sample", int'(sample_a), 128);
        step(17);
        ready_a = 1'b1;
        step(19);
        ready_a = 1'b0;
        step(38);
        ready_a = 1'b1;
        step(1);
        chk("tick_xfer_valid", int'(valid_a), 1);
        chk("tick_xfer_sample", int'(sample_a), 199);
        step(1);
        ready_a = 1'b0;
        step(19);
        chk("pending_sample", int'(sample_a), 209);
        step(1);
        nrst_a = 1'b0;
        #1;
        chk("midrst_valid", int'(valid_a), 0);
        chk("midrst_sample", int'(sample_a), 0);
        chk("overrun_count", deliv_a.size(), 4);
        if (deliv_a.size() >= 4) begin
          chk("overrun_d0", deliv_a[0], 128);
          chk("overrun_d1", deliv_a[1], 177);
          chk("overrun_d2", deliv_a[2], 188);
          chk("overrun_d3", deliv_a[3], 199);
        end
        deliv_a.delete();
        step(5);
        ready_a = 1'b1;
        nrst_a  = 1'b1;
        step(20 * 66 + 2);
        chk("stream_count", deliv_a.size(), 66);
        if (deliv_a.size() >= 66) begin
          chk("stream_s0", deliv_a[0], 128);
          chk("stream_s1", deliv_a[1], 140);
          chk("stream_s16", deliv_a[16], 255);
          chk("stream_s32", deliv_a[32], 128);
          chk("stream_s48", deliv_a[48], 1);
          chk("stream_wrap0", deliv_a[64], deliv_a[0]);
          chk("stream_wrap1", deliv_a[65], deliv_a[1]);
        end
      end
      begin : seq_b
        step(200);
        ready_b = 1'b1;
        step(4799);
        chk("late_pre_valid", int'(valid_b), 0);
        step(1);
        chk("late_valid", int'(valid_b), 1);
        chk("late_sample", int'(sample_b), 128);
        step(1);
        chk("late_accepted", int'(valid_b), 0);
        chk("late_count", deliv_b.size(), 1);
        if (deliv_b.size() >= 1) chk("late_d0", deliv_b[0], 128);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
